exec_wb_stage: RTL and testbench
================================

# exec_wb_stage

Execute/write-back stage fed directly by the control subsystem: it consumes the fetched `instruction` plus the decoder's `valid_instr`, `alu_add` and `alu_sub` flags each cycle. It performs the following per instruction:
- reads rs1/rs2 from a parity-protected 32x32 register file;
- computes the ADD/SUB result and registers it;
- writes it back one cycle later, with WB->EX forwarding.

Fault-tolerance hooks are a sticky parity-error flag, a single-bit fault-injection port, and a retire counter for the bench and the system monitor.

## Interface
- `XLEN`, 32, datapath width
- `NREG`, 32, architectural registers (index width 5)
- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `instruction` in 32: instruction from fetch; rs1=[19:15], rs2=[24:20], rd=[11:7]
- `valid_instr` in 1: decoder says instruction is a legal R-type
- `alu_add` in 1: decoder selects ADD
- `alu_sub` in 1: decoder selects SUB
- `ld_en` in 1: preload write strobe (boot/bench)
- `ld_addr` in 5: preload register index
- `ld_data` in 32: preload data, written with correct parity
- `inj_en` in 1: fault-injection strobe
- `inj_reg` in 5: register to corrupt
- `inj_bit` in 5: data bit to flip (parity not updated)
- `dbg_addr` in 5: debug read index
- `dbg_data` out 32: combinational read of the regfile data, no forwarding
- `wb_en` out 1: write-back occurring this cycle
- `wb_rd` out 5: write-back destination
- `wb_data` out 32: write-back value
- `retire_count` out 32: executed-instruction count
- `parity_err` out 1: sticky parity mismatch seen
- `err_reg` out 5: index of first failing register

## Operation
- EX issues when `valid_instr`=1 and exactly one of `alu_add`/`alu_sub` is set; otherwise the cycle is a bubble (nothing latched, no count).
- Operands:
  - x0 reads 0.
  - If WB holds a valid write to a nonzero rd equal to rs, the WB value is forwarded.
  - Otherwise the regfile entry is used.
- Result:
  - ADD: rs1+rs2 mod 2^32.
  - SUB: rs1-rs2 mod 2^32.
  - Overflow is ignored.
- WB register captures {valid, rd, result} on the issue edge; at the next edge the regfile is written if valid and rd≠0.
- `wb_en` = WB valid && rd≠0. `wb_rd`/`wb_data` reflect the WB register.
- `retire_count` increments on every issue, including rd=0, and wraps 0xFFFFFFFF→0.
- Each entry stores data plus an even-parity bit.
- Parity check applies on every EX read of a nonzero, non-forwarded operand. On mismatch, `parity_err` is set sticky until `rst`. `err_reg` is loaded only on the first error; if both operands fail, rs1 takes priority. Corrupted data is still used.
- Regfile write priority to the same entry in one cycle: WB > `ld` > `inj`. The losing writes are dropped.
- `ld`/`inj` with addr 0 are ignored.

## Timing
- Reset (synchronous): all outputs 0. Regfile data and parity cleared to 0. WB valid cleared. Any in-flight instruction is discarded.
- Latency: issue at edge N → `wb_en`/`wb_data` visible after edge N → regfile updated at edge N+1.
- Back-to-back dependency has zero stalls (forwarding). A dependency at distance 2 reads the regfile, which was written at the same edge as the second issue's WB capture.
- `ld`/`inj` take effect at the edge; they are visible to EX reads the following cycle.
- A preload to a register currently held in WB is overwritten by the WB write at the same edge (WB wins).
- `rst` asserted mid-stream: the next edge clears everything; the first issue after deassertion behaves as from power-up.

## Structure
- Package `cpu_pkg`: `XLEN`, `OPC_RTYPE`=7'b0110011, field position constants (RS1_LSB, RS2_LSB, RD_LSB), `FUNCT7_SUB`=7'b0100000.
- Sub-module `regfile_parity`: 32 entries of {data, parity}. Two combinational read ports returning data and `perr`, one prioritized write port, an injection port and a debug port. The top level holds operand mux/forwarding, ALU, WB register, counter and error logic.

## Test plan
- Preload x1=5, x2=7; issue 0x002081B3 (ADD x3,x1,x2) → next cycle `wb_en`=1, `wb_rd`=3, `wb_data`=12; `dbg_data`(x3)=12 one edge later; `retire_count`=1.
- Issue 0x40208233 (SUB x4,x1,x2) → `wb_data`=0xFFFFFFFE, `wb_rd`=4.
- Issue ADD x3,x1,x2 then 0x003182B3 (ADD x5,x3,x3) on consecutive cycles → x5=24 via forwarding, no bubble.
- Issue 0x00208033 (rd=x0) → `wb_en`=0, x0 reads 0, `retire_count` still increments. Also `valid_instr`=1 with `alu_add`=`alu_sub`=1 → bubble, no count.
- Inject x1 bit0 (x1 5→4), then ADD x3,x1,x2 → `parity_err`=1, `err_reg`=1, `wb_data`=11. A second error on x2 leaves `err_reg`=1.
- Assert `rst` for one cycle while an instruction is in WB → `wb_en`=0, `retire_count`=0, `parity_err`=0, regfile all zero.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the execute/write-back slice.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] FUNCT7_SUB = 7'b0100000;

    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   word_t;

    // Contents of the write-back pipeline register
    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        word_t    data;
    } wb_t;

    // ALU operation as decoded from the one-hot add/sub flags
    typedef enum logic [1:0] {
        ALU_NONE = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_SUB  = 2'd2
    } alu_op_e;

    // Extract a register index field starting at bit position lsb
    function automatic reg_idx_t reg_field(input word_t instr, input int lsb);
        return instr[lsb +: REG_AW];
    endfunction

endpackage

// File: rtl/regfile_parity.sv
// 32x32 register file where every entry carries an even-parity bit.
// Two combinational read ports report a parity mismatch alongside the data.
// One write port serves WB, preload and fault injection with WB > ld > inj.
module regfile_parity
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t rs1_addr,
    output word_t    rs1_data,
    output logic     rs1_perr,
    input  reg_idx_t rs2_addr,
    output word_t    rs2_data,
    output logic     rs2_perr,
    input  logic     we,
    input  reg_idx_t waddr,
    input  word_t    wdata,
    input  logic     ld_en,
    input  reg_idx_t ld_addr,
    input  word_t    ld_data,
    input  logic     inj_en,
    input  reg_idx_t inj_reg,
    input  reg_idx_t inj_bit,
    input  reg_idx_t dbg_addr,
    output word_t    dbg_data
);

    word_t mem_data [NREG];
    logic  mem_par  [NREG];

    assign rs1_data = mem_data[rs1_addr];
    assign rs2_data = mem_data[rs2_addr];
    assign rs1_perr = (^mem_data[rs1_addr]) ^ mem_par[rs1_addr];
    assign rs2_perr = (^mem_data[rs2_addr]) ^ mem_par[rs2_addr];
    assign dbg_data = mem_data[dbg_addr];

    // Per-entry prioritized update; entry 0 is never written so x0 stays zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_data[i] <= '0;
                mem_par[i]  <= 1'b0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (we && waddr == reg_idx_t'(i)) begin
                    mem_data[i] <= wdata;
                    mem_par[i]  <= ^wdata;
                end else if (ld_en && ld_addr == reg_idx_t'(i)) begin
                    mem_data[i] <= ld_data;
                    mem_par[i]  <= ^ld_data;
                end else if (inj_en && inj_reg == reg_idx_t'(i)) begin
                    mem_data[i] <= mem_data[i] ^ (word_t'(1) << inj_bit);
                end
            end
        end
    end

endmodule

// File: rtl/exec_wb_stage.sv
// Execute/write-back stage: operand fetch with WB->EX forwarding, ADD/SUB,
// a single write-back register, retire counter and sticky parity reporting.
module exec_wb_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        valid_instr,
    input  logic        alu_add,
    input  logic        alu_sub,
    input  logic        ld_en,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic        inj_en,
    input  logic [4:0]  inj_reg,
    input  logic [4:0]  inj_bit,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] retire_count,
    output logic        parity_err,
    output logic [4:0]  err_reg
);

    reg_idx_t rs1, rs2, rd;
    wb_t      wb_q;
    alu_op_e  alu_op;
    logic     issue;
    word_t    rf_rs1_data, rf_rs2_data;
    logic     rf_rs1_perr, rf_rs2_perr;
    logic     fwd1, fwd2;
    word_t    op_a, op_b, result;
    logic     err1, err2;
    logic     unused_instr_bits;

    assign rs1 = reg_field(instruction, RS1_LSB);
    assign rs2 = reg_field(instruction, RS2_LSB);
    assign rd  = reg_field(instruction, RD_LSB);

    // Opcode/funct bits are already interpreted by the upstream decoder
    assign unused_instr_bits = ^{instruction[6:0], instruction[14:12], instruction[31:25]};

    regfile_parity u_rf (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1),
        .rs1_data (rf_rs1_data),
        .rs1_perr (rf_rs1_perr),
        .rs2_addr (rs2),
        .rs2_data (rf_rs2_data),
        .rs2_perr (rf_rs2_perr),
        .we       (wb_en),
        .waddr    (wb_q.rd),
        .wdata    (wb_q.data),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .inj_en   (inj_en),
        .inj_reg  (inj_reg),
        .inj_bit  (inj_bit),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Decode the add/sub flags; both or neither set means no operation
    always_comb begin
        alu_op = ALU_NONE;
        unique case ({alu_add, alu_sub})
            2'b10:   alu_op = ALU_ADD;
            2'b01:   alu_op = ALU_SUB;
            default: alu_op = ALU_NONE;
        endcase
    end

    assign issue = valid_instr && (alu_op != ALU_NONE);
    assign fwd1  = wb_en && (wb_q.rd == rs1);
    assign fwd2  = wb_en && (wb_q.rd == rs2);

    // Operand selection: x0, then forwarded WB value, then regfile; parity
    // is only meaningful for nonzero operands that actually came from storage
    always_comb begin
        op_a = rf_rs1_data;
        op_b = rf_rs2_data;
        err1 = 1'b0;
        err2 = 1'b0;
        if (rs1 == '0) begin
            op_a = '0;
        end else if (fwd1) begin
            op_a = wb_q.data;
        end else begin
            err1 = rf_rs1_perr;
        end
        if (rs2 == '0) begin
            op_b = '0;
        end else if (fwd2) begin
            op_b = wb_q.data;
        end else begin
            err2 = rf_rs2_perr;
        end
        result = (alu_op == ALU_SUB) ? (op_a - op_b) : (op_a + op_b);
    end

    // WB capture, retire counting and first-error latching on each issue
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q         <= '0;
            retire_count <= '0;
            parity_err   <= 1'b0;
            err_reg      <= '0;
        end else begin
            wb_q.valid <= issue;
            if (issue) begin
                wb_q.rd      <= rd;
                wb_q.data    <= result;
                retire_count <= retire_count + word_t'(1);
                if (err1 || err2) begin
                    parity_err <= 1'b1;
                    if (!parity_err) begin
                        err_reg <= err1 ? rs1 : rs2;
                    end
                end
            end
        end
    end

    assign wb_en   = wb_q.valid && (wb_q.rd != '0);
    assign wb_rd   = wb_q.rd;
    assign wb_data = wb_q.data;

endmodule

// File: tb/tb_exec_wb_stage.sv
// Self-checking bench for exec_wb_stage: an architectural model tracks register
// values, a pending write-back and a per-register "corrupted" flag, and is
// compared against the DUT every cycle; directed literals pin the model.
module tb_exec_wb_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        valid_instr, alu_add, alu_sub;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        inj_en;
    logic [4:0]  inj_reg, inj_bit;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] retire_count;
    logic        parity_err;
    logic [4:0]  err_reg;

    int checks = 0;
    int errors = 0;

    exec_wb_stage dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .valid_instr  (valid_instr),
        .alu_add      (alu_add),
        .alu_sub      (alu_sub),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .inj_en       (inj_en),
        .inj_reg      (inj_reg),
        .inj_bit      (inj_bit),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .retire_count (retire_count),
        .parity_err   (parity_err),
        .err_reg      (err_reg)
    );

    always #5 clk = ~clk;

    // Architectural model state
    logic [31:0] m_regs [32];
    bit          m_bad  [32];
    bit          m_wb_valid;
    logic [4:0]  m_wb_rd;
    logic [31:0] m_wb_data;
    logic [31:0] m_retire;
    bit          m_perr;
    logic [4:0]  m_err_reg;
    bit          m_ready = 1'b0;

    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_a, m_b, m_res;
    bit          m_bad_a, m_bad_b, m_issue;

    // Value an instruction sees for register r, and whether storage was corrupt
    function automatic void read_op(input logic [4:0] r, output logic [31:0] v, output bit bad);
        bad = 1'b0;
        if (r == 5'd0) begin
            v = 32'd0;
        end else if (m_wb_valid && m_wb_rd == r) begin
            v = m_wb_data;
        end else begin
            v   = m_regs[r];
            bad = m_bad[r];
        end
    endfunction

    function automatic logic [31:0] mk_rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                             input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, OPC_RTYPE};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    // Advance model one clock edge using the inputs seen at that edge
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_bad[i]  = 1'b0;
            end
            m_wb_valid = 1'b0;
            m_wb_rd    = 5'd0;
            m_wb_data  = 32'd0;
            m_retire   = 32'd0;
            m_perr     = 1'b0;
            m_err_reg  = 5'd0;
            m_ready    = 1'b1;
        end else begin
            m_rs1   = instruction[19:15];
            m_rs2   = instruction[24:20];
            m_rd    = instruction[11:7];
            m_issue = valid_instr && (alu_add != alu_sub);
            read_op(m_rs1, m_a, m_bad_a);
            read_op(m_rs2, m_b, m_bad_b);
            m_res = alu_add ? (m_a + m_b) : (m_a - m_b);
            if (m_issue) begin
                m_retire = m_retire + 32'd1;
                if (m_bad_a || m_bad_b) begin
                    if (!m_perr) m_err_reg = m_bad_a ? m_rs1 : m_rs2;
                    m_perr = 1'b1;
                end
            end
            // lowest priority applied first so later writes override it
            if (inj_en && inj_reg != 5'd0) begin
                m_regs[inj_reg][inj_bit] = ~m_regs[inj_reg][inj_bit];
                m_bad[inj_reg] = ~m_bad[inj_reg];
            end
            if (ld_en && ld_addr != 5'd0) begin
                m_regs[ld_addr] = ld_data;
                m_bad[ld_addr]  = 1'b0;
            end
            if (m_wb_valid && m_wb_rd != 5'd0) begin
                m_regs[m_wb_rd] = m_wb_data;
                m_bad[m_wb_rd]  = 1'b0;
            end
            m_wb_valid = m_issue;
            if (m_issue) begin
                m_wb_rd   = m_rd;
                m_wb_data = m_res;
            end
        end
    end

    // Compare DUT against the model mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (m_ready) begin
            checkOutput("cmp_wb_en", 32'(wb_en), 32'(m_wb_valid && m_wb_rd != 5'd0));
            if (m_wb_valid && m_wb_rd != 5'd0) begin
                checkOutput("cmp_wb_rd", 32'(wb_rd), 32'(m_wb_rd));
                checkOutput("cmp_wb_data", wb_data, m_wb_data);
            end
            checkOutput("cmp_retire", retire_count, m_retire);
            checkOutput("cmp_parity_err", 32'(parity_err), 32'(m_perr));
            checkOutput("cmp_err_reg", 32'(err_reg), 32'(m_err_reg));
            checkOutput("cmp_dbg_data", dbg_data, m_regs[dbg_addr]);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic setIdle();
        instruction = 32'd0;
        valid_instr = 1'b0;
        alu_add     = 1'b0;
        alu_sub     = 1'b0;
        ld_en       = 1'b0;
        inj_en      = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic v, input logic a, input logic s);
        instruction = instr;
        valid_instr = v;
        alu_add     = a;
        alu_sub     = s;
        cycle();
        setIdle();
    endtask

    task automatic loadReg(input logic [4:0] addr, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        cycle();
        ld_en = 1'b0;
    endtask

    task automatic injectBit(input logic [4:0] r, input logic [4:0] b);
        inj_en  = 1'b1;
        inj_reg = r;
        inj_bit = b;
        cycle();
        inj_en = 1'b0;
    endtask

    initial begin
        setIdle();
        ld_addr  = 5'd0;
        ld_data  = 32'd0;
        inj_reg  = 5'd0;
        inj_bit  = 5'd0;
        dbg_addr = 5'd0;
        rst      = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;

        checkOutput("reset_wb_en", 32'(wb_en), 32'd0);
        checkOutput("reset_retire", retire_count, 32'd0);
        checkOutput("reset_parity_err", 32'(parity_err), 32'd0);
        checkOutput("reset_wb_data", wb_data, 32'd0);

        loadReg(5'd1, 32'd5);
        loadReg(5'd2, 32'd7);
        loadReg(5'd3, 32'd100);

        // ADD x3,x1,x2 followed immediately by ADD x5,x3,x3
        applyStimulus(32'h002081B3, 1'b1, 1'b1, 1'b0);
        checkOutput("add_wb_en", 32'(wb_en), 32'd1);
        checkOutput("add_wb_rd", 32'(wb_rd), 32'd3);
        checkOutput("add_wb_data", wb_data, 32'd12);
        checkOutput("add_retire", retire_count, 32'd1);
        applyStimulus(32'h003182B3, 1'b1, 1'b1, 1'b0);
        checkOutput("fwd_wb_rd", 32'(wb_rd), 32'd5);
        checkOutput("fwd_wb_data", wb_data, 32'd24);
        checkOutput("fwd_retire", retire_count, 32'd2);
        dbg_addr = 5'd3;
        #1 checkOutput("dbg_x3", dbg_data, 32'd12);
        cycle();
        dbg_addr = 5'd5;
        #1 checkOutput("dbg_x5", dbg_data, 32'd24);

        // SUB x4,x1,x2
        applyStimulus(32'h40208233, 1'b1, 1'b0, 1'b1);
        checkOutput("sub_wb_rd", 32'(wb_rd), 32'd4);
        checkOutput("sub_wb_data", wb_data, 32'hFFFFFFFE);

        // rd = x0 retires without a write; illegal flag combos are bubbles
        applyStimulus(32'h00208033, 1'b1, 1'b1, 1'b0);
        checkOutput("x0_wb_en", 32'(wb_en), 32'd0);
        checkOutput("x0_retire", retire_count, 32'd4);
        dbg_addr = 5'd0;
        #1 checkOutput("dbg_x0", dbg_data, 32'd0);
        applyStimulus(32'h002081B3, 1'b1, 1'b1, 1'b1);
        checkOutput("bubble_both_retire", retire_count, 32'd4);
        checkOutput("bubble_both_wb_en", 32'(wb_en), 32'd0);
        applyStimulus(32'h002081B3, 1'b0, 1'b1, 1'b0);
        checkOutput("bubble_invalid_retire", retire_count, 32'd4);

        // preload colliding with WB write to the same register: WB wins
        applyStimulus(32'h00208233, 1'b1, 1'b1, 1'b0);
        ld_en    = 1'b1;
        ld_addr  = 5'd4;
        ld_data  = 32'd999;
        dbg_addr = 5'd4;
        cycle();
        ld_en = 1'b0;
        #1 checkOutput("wb_beats_ld", dbg_data, 32'd12);

        // dependency chain at distance 1 and 2, plus an x0 source operand
        applyStimulus(mk_rtype(7'd0,       5'd2, 5'd1, 5'd8),  1'b1, 1'b1, 1'b0);
        applyStimulus(mk_rtype(FUNCT7_SUB, 5'd1, 5'd8, 5'd9),  1'b1, 1'b0, 1'b1);
        checkOutput("chain_sub", wb_data, 32'd7);
        applyStimulus(mk_rtype(7'd0,       5'd9, 5'd8, 5'd10), 1'b1, 1'b1, 1'b0);
        checkOutput("chain_dist2", wb_data, 32'd19);
        applyStimulus(mk_rtype(7'd0,       5'd1, 5'd0, 5'd6),  1'b1, 1'b1, 1'b0);
        checkOutput("x0_operand", wb_data, 32'd5);
        checkOutput("chain_retire", retire_count, 32'd9);
        cycle();

        // fault injection: x1 5->4, then x2 7->15
        injectBit(5'd1, 5'd0);
        applyStimulus(32'h002081B3, 1'b1, 1'b1, 1'b0);
        checkOutput("inj_wb_data", wb_data, 32'd11);
        checkOutput("inj_parity_err", 32'(parity_err), 32'd1);
        checkOutput("inj_err_reg", 32'(err_reg), 32'd1);
        injectBit(5'd2, 5'd3);
        applyStimulus(32'h002003B3, 1'b1, 1'b1, 1'b0);
        checkOutput("inj2_wb_data", wb_data, 32'd15);
        checkOutput("inj2_err_reg", 32'(err_reg), 32'd1);
        checkOutput("inj2_parity_err", 32'(parity_err), 32'd1);

        // reset with an instruction sitting in WB
        applyStimulus(32'h002081B3, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checkOutput("rst_wb_en", 32'(wb_en), 32'd0);
        checkOutput("rst_retire", retire_count, 32'd0);
        checkOutput("rst_parity_err", 32'(parity_err), 32'd0);
        checkOutput("rst_err_reg", 32'(err_reg), 32'd0);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            cycle();
            checkOutput("rst_regfile", dbg_data, 32'd0);
        end
        applyStimulus(32'h002081B3, 1'b1, 1'b1, 1'b0);
        checkOutput("post_rst_wb_en", 32'(wb_en), 32'd1);
        checkOutput("post_rst_wb_data", wb_data, 32'd0);
        checkOutput("post_rst_retire", retire_count, 32'd1);

        repeat (3) cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
